dep_issue_scheduler: RTL

Consumer side of the instruction-dependency table. It accepts each newly buffered instruction together with the dependency vector the table produced for it, and tracks which in-flight instructions each one still waits on. When an instruction completes, its dependency bits are cleared from every other entry. Dependency-free entries are handed to the execute stage one at a time over a valid/ready handshake.

---
 rtl/dep_issue_scheduler.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dep_issue_scheduler.sv
// Tracks per-slot dependency rows and offers dependency-free slots to execute.
// Latency: a slot whose row becomes empty at edge E is offered after edge E+2.
// Backpressure: the offer holds until issue_ready; an offer reloads on the handshake edge.
module dep_issue_scheduler #(
   parameter int bs = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_valid,
   input  logic [$clog2(bs)-1:0] alloc_index,
   input  logic [bs-1:0]         alloc_idt,
   input  logic                  done_valid,
   input  logic [$clog2(bs)-1:0] done_index,
   output logic                  issue_valid,
   output logic [$clog2(bs)-1:0] issue_index,
   input  logic                  issue_ready,
   output logic [bs-1:0]         busy,
   output logic [$clog2(bs):0]   count,
   output logic                  full,
   output logic                  alloc_err
);

   localparam int IW = $clog2(bs);

   typedef enum logic [2:0] {
      S_FREE,
      S_WAIT,
      S_READY,
      S_OFFERED,
      S_ISSUED
   } slot_state_e;

   slot_state_e   state_q [bs];
   slot_state_e   state_d [bs];
   logic [bs-1:0] dep_q   [bs];
   logic [bs-1:0] dep_d   [bs];

   logic          issue_valid_q, issue_valid_d;
   logic [IW-1:0] issue_index_q, issue_index_d;
   logic          alloc_err_q, alloc_err_d;

   logic          done_eff;
   logic [bs-1:0] done_mask;
   logic [bs-1:0] busy_eff;
   logic          handshake;
   logic          offer_load;
   logic          alloc_ok;
   logic [bs-1:0] cand;
   logic          pick_vld;
   logic [IW-1:0] pick_idx;

   // Occupancy view: any slot not FREE is busy; count/full follow from it.
   always_comb begin
      count = '0;
      for (int s = 0; s < bs; s++) begin
         busy[s] = (state_q[s] != S_FREE);
         count   = count + {{IW{1'b0}}, busy[s]};
      end
      full = (count == (IW+1)'(bs));
   end

   // Per-cycle events and lowest-index READY candidate selection.
   always_comb begin
      done_eff  = done_valid && (state_q[done_index] == S_ISSUED);
      done_mask = '0;
      if (done_eff) begin
         done_mask[done_index] = 1'b1;
      end
      busy_eff   = busy & ~done_mask;
      handshake  = issue_valid_q && issue_ready;
      offer_load = !issue_valid_q || handshake;
      // A completion on the target slot frees it in time for this allocation.
      alloc_ok   = alloc_valid &&
                   ((state_q[alloc_index] == S_FREE) || (done_eff && (done_index == alloc_index)));
      for (int s = 0; s < bs; s++) begin
         cand[s] = (state_q[s] == S_READY);
      end
      if (handshake) begin
         cand[issue_index_q] = 1'b0;
      end
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int s = bs - 1; s >= 0; s--) begin
         if (cand[s]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(s);
         end
      end
   end

   // Next-state for slot states, dependency rows, the offer register and alloc_err.
   always_comb begin
      for (int s = 0; s < bs; s++) begin
         state_d[s] = state_q[s];
         dep_d[s]   = dep_q[s] & ~done_mask;
         // Row is judged on its registered value so the READY step costs one cycle.
         if ((state_q[s] == S_WAIT) && (dep_q[s] == '0)) begin
            state_d[s] = S_READY;
         end
         if ((state_q[s] == S_ISSUED) && done_eff && (done_index == IW'(s))) begin
            state_d[s] = S_FREE;
         end
         if (handshake && (issue_index_q == IW'(s))) begin
            state_d[s] = S_ISSUED;
         end
         if (offer_load && pick_vld && (pick_idx == IW'(s))) begin
            state_d[s] = S_OFFERED;
         end
         if (alloc_ok && (alloc_index == IW'(s))) begin
            state_d[s] = S_WAIT;
            dep_d[s]   = alloc_idt & busy_eff;
            dep_d[s][s] = 1'b0;
         end
      end
      issue_valid_d = issue_valid_q;
      issue_index_d = issue_index_q;
      if (offer_load) begin
         issue_valid_d = pick_vld;
         if (pick_vld) begin
            issue_index_d = pick_idx;
         end
      end
      alloc_err_d = alloc_valid && !alloc_ok;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < bs; s++) begin
            state_q[s] <= S_FREE;
            dep_q[s]   <= '0;
         end
         issue_valid_q <= 1'b0;
         issue_index_q <= '0;
         alloc_err_q   <= 1'b0;
      end else begin
         for (int s = 0; s < bs; s++) begin
            state_q[s] <= state_d[s];
            dep_q[s]   <= dep_d[s];
         end
         issue_valid_q <= issue_valid_d;
         issue_index_q <= issue_index_d;
         alloc_err_q   <= alloc_err_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_index = issue_index_q;
   assign alloc_err   = alloc_err_q;

endmodule
